// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-atomic arbiter that feeds one uart_tx serializer.
// Optional owner-stall release is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arb #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int UART_BPS       = 115200,
  parameter int N_REQ          = 4,
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int BYTE_CYCLES = (CLK_FREQ / UART_BPS) * 10 + GUARD_CYCLES;
  localparam int CW = $clog2(BYTE_CYCLES);
  localparam int OW = $clog2(N_REQ);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BYTE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state_q;
  logic [OW-1:0]     owner_q;
  logic [OW-1:0]     last_owner_q;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  req_ready_q;
  logic              busy_q;
  logic              last_q;
  logic [CW-1:0]     cnt_q;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;

  logic              rr_hit_d;
  logic [OW-1:0]     rr_pick_d;
  logic              own_valid;
  logic              own_last;
  logic [7:0]        own_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);
  logic [SW-1:0] stall_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // Smallest offset from last_owner+1 wins, so scan offsets downward and let the last hit stand.
  always_comb begin
    rr_hit_d  = 1'b0;
    rr_pick_d = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && (((int'(last_owner_q) + k) % N_REQ) == i)) begin
          rr_hit_d  = 1'b1;
          rr_pick_d = OW'(i);
        end
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == OW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*8 +: 8];
      end
    end
  end

  // valid/ready: a byte moves on a rising edge where req_valid[i] and req_ready[i] are both high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(N_REQ - 1);
      grant_q      <= '0;
      req_ready_q  <= '0;
      busy_q       <= 1'b0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
`ifdef UART_ARB_TIMEOUT_EN
      stall_q      <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rr_hit_d) begin
            owner_q     <= rr_pick_d;
            grant_q     <= N_REQ'(1) << rr_pick_d;
            req_ready_q <= N_REQ'(1) << rr_pick_d;
            busy_q      <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (own_valid) begin
            tx_data_q   <= own_data;
            tx_start_q  <= 1'b1;
            last_q      <= own_last;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= '0;
            state_q     <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
            stall_q     <= '0;
          end else if (stall_q == STALL_LAST) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            req_ready_q  <= '0;
            busy_q       <= 1'b0;
            last_owner_q <= owner_q;
            stall_q      <= '0;
          end else begin
            stall_q <= stall_q + 1'b1;
`endif
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (last_q) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            last_owner_q <= owner_q;
          end else begin
            req_ready_q <= grant_q;
            state_q     <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign grant     = grant_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
